// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM state
// encoding and the two's-complement overflow rule used on the final nibble.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow occurs when both operands share a sign and the result does not.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple carry adder: the single arithmetic element the serial adder
// time-shares across all nibbles of an operand.
module nibble_serial_adder_rca
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  // Ripple the carry bit by bit through full-adder cells.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder. Operands are captured on a valid/ready accept,
// then fed one nibble per cycle (LSB nibble first) through a single 4-bit RCA
// with the carry chained between passes. The result is held with out_valid
// until the consumer takes it.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int SHIFT_W = $clog2(NIBBLE_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]         a_reg;
  logic [WIDTH-1:0]         b_reg;
  logic [CNT_W-1:0]         count;
  logic                     carry;
  logic [CNT_W+SHIFT_W-1:0] base;
  logic                     accept;
  logic                     last;

  logic [NIBBLE_W-1:0] rca_a;
  logic [NIBBLE_W-1:0] rca_b;
  logic [NIBBLE_W-1:0] rca_sum;
  logic                rca_cout;

  assign accept = in_valid && in_ready;
  assign last   = (count == LAST);
  assign base   = {count, {SHIFT_W{1'b0}}};
  assign rca_a  = a_reg[base +: NIBBLE_W];
  assign rca_b  = b_reg[base +: NIBBLE_W];

  nibble_serial_adder_rca u_rca (
    .a    (rca_a),
    .b    (rca_b),
    .cin  (carry),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  // State register; reset always returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept, run one pass per nibble, then wait for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake outputs decode straight from state so they can never overlap.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, per-nibble result writeback and final carry/overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      count    <= '0;
      carry    <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg    <= A;
            b_reg    <= B;
            carry    <= Cin;
            count    <= '0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
          end
        end
        RUN: begin
          Sum[base +: NIBBLE_W] <= rca_sum;
          carry                 <= rca_cout;
          if (last) begin
            Cout     <= rca_cout;
            Overflow <= add_overflow(a_reg[WIDTH-1], b_reg[WIDTH-1],
                                     rca_sum[NIBBLE_W-1]);
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Simulation-only sanity checks on parameterisation and handshake exclusivity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((WIDTH % NIBBLE_W) == 0 && WIDTH >= NIBBLE_W);
      assert (!(out_valid && in_ready));
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random self-checking bench for nibble_serial_adder at WIDTH 4, 16 and 32.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter used to measure accept spacing.
  always @(posedge clk) cycle <= cycle + 1;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        in_valid32, in_ready32, out_valid32, out_ready32, cin32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .Cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .Sum(sum4), .Cout(cout4), .Overflow(ovf4)
  );

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .Cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .Sum(sum16), .Cout(cout16), .Overflow(ovf16)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(a32), .B(b32), .Cin(cin32), .out_valid(out_valid32), .out_ready(out_ready32),
    .Sum(sum32), .Cout(cout32), .Overflow(ovf32)
  );

  function automatic logic readValid(input int w);
    case (w)
      4:       return out_valid4;
      32:      return out_valid32;
      default: return out_valid16;
    endcase
  endfunction

  function automatic logic readReady(input int w);
    case (w)
      4:       return in_ready4;
      32:      return in_ready32;
      default: return in_ready16;
    endcase
  endfunction

  function automatic logic [31:0] readSum(input int w);
    case (w)
      4:       return {28'd0, sum4};
      32:      return sum32;
      default: return {16'd0, sum16};
    endcase
  endfunction

  function automatic logic readCout(input int w);
    case (w)
      4:       return cout4;
      32:      return cout32;
      default: return cout16;
    endcase
  endfunction

  function automatic logic readOvf(input int w);
    case (w)
      4:       return ovf4;
      32:      return ovf32;
      default: return ovf16;
    endcase
  endfunction

  task automatic driveIn(input int w, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
    case (w)
      4:       begin in_valid4  = v; a4  = a[3:0];  b4  = b[3:0];  cin4  = c; end
      32:      begin in_valid32 = v; a32 = a;       b32 = b;       cin32 = c; end
      default: begin in_valid16 = v; a16 = a[15:0]; b16 = b[15:0]; cin16 = c; end
    endcase
  endtask

  task automatic setOutReady(input int w, input logic v);
    case (w)
      4:       out_ready4  = v;
      32:      out_ready32 = v;
      default: out_ready16 = v;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present operands, wait for the accept edge, scramble inputs, then count
  // edges until out_valid. Leaves the DUT in DONE with out_ready low.
  task automatic applyStimulus(input int w, input logic [31:0] a, input logic [31:0] b,
                               input logic c, output int lat);
    int guard;
    @(negedge clk);
    driveIn(w, 1'b1, a, b, c);
    guard = 0;
    while (!readReady(w) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 driveIn(w, 1'b0, ~a, ~b, ~c);
    lat = 0;
    while (!readValid(w) && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    @(negedge clk);
  endtask

  task automatic releaseOutput(input int w);
    setOutReady(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    setOutReady(w, 1'b0);
    checkOutput($sformatf("w%0d_ready_after_release", w), {31'd0, readReady(w)}, 32'd1);
    checkOutput($sformatf("w%0d_valid_after_release", w), {31'd0, readValid(w)}, 32'd0);
  endtask

  task automatic checkAdd(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [31:0] esum, input logic ecout,
                          input logic eovf);
    int lat;
    applyStimulus(w, a, b, c, lat);
    checkOutput($sformatf("w%0d_latency_%0h", w, a), lat, w / 4);
    checkOutput($sformatf("w%0d_sum_%0h_%0h", w, a, b), readSum(w), esum);
    checkOutput($sformatf("w%0d_cout_%0h_%0h", w, a, b), {31'd0, readCout(w)}, {31'd0, ecout});
    checkOutput($sformatf("w%0d_ovf_%0h_%0h", w, a, b), {31'd0, readOvf(w)}, {31'd0, eovf});
    releaseOutput(w);
  endtask

  initial begin
    int          lat;
    int          guard;
    int          acc;
    int          prev_acc;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] expv;

    rst = 1'b1;
    driveIn(4, 1'b0, 32'd0, 32'd0, 1'b0);
    driveIn(16, 1'b0, 32'd0, 32'd0, 1'b0);
    driveIn(32, 1'b0, 32'd0, 32'd0, 1'b0);
    setOutReady(4, 1'b0);
    setOutReady(16, 1'b0);
    setOutReady(32, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_out_valid", {31'd0, out_valid16}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready16}, 32'd1);
    checkOutput("rst_sum", {16'd0, sum16}, 32'd0);
    checkOutput("rst_cout", {31'd0, cout16}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf16}, 32'd0);
    checkOutput("rst_in_ready_w4", {31'd0, in_ready4}, 32'd1);
    checkOutput("rst_in_ready_w32", {31'd0, in_ready32}, 32'd1);

    $display("[TB] directed adds, WIDTH=16");
    checkAdd(16, 32'h1234, 32'h4321, 1'b0, 32'h5555, 1'b0, 1'b0);
    checkAdd(16, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0);
    checkAdd(16, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1);
    checkAdd(16, 32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 1'b1);
    checkAdd(16, 32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, 1'b0);

    $display("[TB] directed adds, WIDTH=4");
    checkAdd(4, 32'h4, 32'h1, 1'b0, 32'h5, 1'b0, 1'b0);
    checkAdd(4, 32'hF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkAdd(4, 32'h7, 32'h1, 1'b0, 32'h8, 1'b0, 1'b1);
    checkAdd(4, 32'h8, 32'h8, 1'b0, 32'h0, 1'b1, 1'b1);

    $display("[TB] directed adds, WIDTH=32");
    checkAdd(32, 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0);
    checkAdd(32, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    checkAdd(32, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    checkAdd(32, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    checkAdd(32, 32'hFFFFFFFE, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);

    $display("[TB] backpressure in DONE");
    applyStimulus(16, 32'h0F0F, 32'h00F1, 1'b0, lat);
    checkOutput("bp_latency", lat, 32'd4);
    checkOutput("bp_sum", {16'd0, sum16}, 32'h1000);
    for (int i = 0; i < 5; i++) begin
      driveIn(16, 1'b1, 32'hAAAA, 32'h5555, 1'b1);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("bp_hold_sum_%0d", i), {16'd0, sum16}, 32'h1000);
      checkOutput($sformatf("bp_hold_in_ready_%0d", i), {31'd0, in_ready16}, 32'd0);
      checkOutput($sformatf("bp_hold_out_valid_%0d", i), {31'd0, out_valid16}, 32'd1);
    end
    driveIn(16, 1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("bp_cout", {31'd0, cout16}, 32'd0);
    releaseOutput(16);

    $display("[TB] reset during RUN");
    @(negedge clk);
    driveIn(16, 1'b1, 32'h1234, 32'h4321, 1'b0);
    @(posedge clk);
    #1 driveIn(16, 1'b0, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("run_partial_sum", {16'd0, sum16}, 32'h0005);
    checkOutput("run_out_valid", {31'd0, out_valid16}, 32'd0);
    checkOutput("run_in_ready", {31'd0, in_ready16}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_out_valid", {31'd0, out_valid16}, 32'd0);
    checkOutput("midrst_sum", {16'd0, sum16}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready16}, 32'd1);
    checkAdd(16, 32'h0000, 32'h0000, 1'b1, 32'h0001, 1'b0, 1'b0);

    $display("[TB] random back-to-back adds");
    @(negedge clk);
    setOutReady(16, 1'b1);
    prev_acc = 0;
    for (int i = 0; i < 200; i++) begin
      guard = 0;
      while (!in_ready16 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rc   = 1'($urandom_range(0, 1));
      expv = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      driveIn(16, 1'b1, {16'd0, ra}, {16'd0, rb}, rc);
      acc = cycle;
      if (i > 0) checkOutput($sformatf("rnd_spacing_%0d", i), acc - prev_acc, 32'd6);
      prev_acc = acc;
      @(posedge clk);
      @(negedge clk);
      guard = 0;
      while (!out_valid16 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      checkOutput($sformatf("rnd_sum_%0d", i), {16'd0, sum16}, {16'd0, expv[15:0]});
      checkOutput($sformatf("rnd_cout_%0d", i), {31'd0, cout16}, {31'd0, expv[16]});
      checkOutput($sformatf("rnd_ovf_%0d", i), {31'd0, ovf16},
                  {31'd0, (ra[15] == rb[15]) && (expv[15] != ra[15])});
      @(negedge clk);
    end
    driveIn(16, 1'b0, 32'd0, 32'd0, 1'b0);
    setOutReady(16, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
